popcount_frame_acc: RTL and testbench
=====================================

Name: popcount_frame_acc

Overview:
- Downstream consumer of the combinational one-count block `for_test` (32-bit `in` → 32-bit `sum` = number of set bits).
- Accepts a stream of 32-bit words over a valid/ready handshake and counts the set bits in each word.
- Adds the per-word counts across a frame of up to FRAME_LEN words.
- Presents the frame total and word count on a held output handshake; used as the bit-statistics stage after data capture.

Parameters:
- FRAME_LEN, 8, maximum words per frame; legal range 1..255.
- ACC_W, 16, width of the total accumulator; must satisfy 2^ACC_W > 32*FRAME_LEN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  32  word whose set bits are counted.
- in_last  input  1  marks the final word of a short frame; sampled only on a handshake.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- out_total  output  ACC_W  sum of one-counts over the frame.
- out_words  output  8  number of words in the frame (1..FRAME_LEN).

Behaviour:
- Reset (asynchronous, active-high):
  - state=ACCUM, acc=0, cnt=0.
  - out_valid=0, out_total=0, out_words=0.
  - in_ready=1 once reset deasserts.
- Per-word count:
  - pop = for_test.sum(in_data), range 0..32, combinational.
  - pop is zero-extended to ACC_W before the add.
- Input handshake: fires when in_valid && in_ready, in the same cycle.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On handshake with cnt < FRAME_LEN-1 and in_last=0: acc <= acc+pop, cnt <= cnt+1.
  - On handshake with cnt == FRAME_LEN-1 or in_last=1:
    - out_total <= acc+pop, out_words <= cnt+1.
    - acc <= 0, cnt <= 0.
    - state <= HOLD.
  - With no handshake, all registers hold; gaps in in_valid are legal.
- State HOLD:
  - in_ready=0, out_valid=1.
  - out_total and out_words stay stable until out_ready=1.
  - On out_ready=1: out_valid <= 0, state <= ACCUM. in_ready returns to 1 in the next cycle; there is no same-cycle accept.
  - out_total and out_words keep their last value after acceptance (not cleared).
- Latency: out_valid rises the cycle after the final-word handshake. Throughput is one word per cycle, with one bubble per frame plus any downstream stall.
- Boundaries:
  - FRAME_LEN=1: every word is a frame.
  - in_last on the first word: out_words=1.
  - in_last while cnt == FRAME_LEN-1: a single close, no double count.
  - Zero words give pop=0 but still count toward out_words.
  - acc cannot overflow given the ACC_W rule.
- Reset mid-frame or during HOLD: the partial frame is discarded, the pending result is lost, and all outputs return to their reset values immediately.
- Upstream holds in_data stable while in_valid=1 && in_ready=0; the block does not check this.

Decomposition:
- Shared package: state encoding (ACCUM=1'b0, HOLD=1'b1) and the localparam POP_W=6.
- One sub-module: the existing `for_test`, instantiated for pop. Only sum[5:0] is used; upper bits are ignored.
- All other logic is one always block for the FSM/datapath plus continuous assigns for in_ready and out_valid.

Test Plan:
- Full-ones frame: 8 words of 0xFFFFFFFF, back-to-back, out_ready=1 → one cycle after word 8, out_valid=1, out_total=256, out_words=8. in_ready low for exactly 1 cycle.
- Short frame: 0x00000001, 0x00000003, 0x00000007 with in_last on the third, in_valid gaps between beats → out_total=6, out_words=3.
- Backpressure: after a frame of 8×0x0000FFFF, hold out_ready=0 for 5 cycles → out_valid=1, out_total=128, in_ready=0 throughout. Words offered meanwhile are not consumed. Accepted on out_ready=1.
- Zero frame: 8×0x00000000 → out_total=0, out_words=8. The next frame of 8×0x80000000 gives 8, proving acc cleared between frames.
- Reset mid-frame: 4 words of 0xFFFFFFFF, then reset asserted asynchronously between edges → outputs 0 immediately. The following 8×0x00000001 frame yields out_total=8, not 136.
- FRAME_LEN=1 build: words 0xAAAAAAAA then 0x0000000F → two results, 16 then 4, each with out_words=1.

Source files
------------

// File: rtl/popcount_frame_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : popcount_frame_acc_pkg
// Brief   : Shared state encoding and widths for the frame popcount stage.
// Revision: 1.0 - initial release
// ============================================================================
package popcount_frame_acc_pkg;

  // Width of a single-word one-count (0..32 fits in 6 bits).
  localparam int POP_W = 6;

  // Width of the frame word counter and the out_words port.
  localparam int WORDS_W = 8;

  // Frame state encoding.
  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

endpackage : popcount_frame_acc_pkg
`default_nettype wire

// File: rtl/for_test.sv
`default_nettype none
// ============================================================================
// Module  : for_test
// Brief   : Combinational one-count of a 32-bit word.
// Revision: 1.0 - initial release
// ============================================================================
module for_test (
  input  logic [31:0] in,
  output logic [31:0] sum
);

  // Sum every bit of the input word.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 32; i++) begin
      sum = sum + {31'd0, in[i]};
    end
  end

endmodule : for_test
`default_nettype wire

// File: rtl/popcount_frame_acc.sv
`default_nettype none
// ============================================================================
// Module  : popcount_frame_acc
// Brief   : Counts set bits per input word and accumulates them over a frame
//           of up to FRAME_LEN words; the frame total and word count are
//           presented on a held valid/ready output.
// Revision: 1.0 - initial release
// ============================================================================
module popcount_frame_acc
  import popcount_frame_acc_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_total,
  output logic [WORDS_W-1:0]   out_words
);

  // Counter value of the final word slot of a full frame.
  localparam logic [WORDS_W-1:0] LAST_IDX = WORDS_W'(FRAME_LEN - 1);

  logic [0:0]         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WORDS_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]   total_q, total_d;
  logic [WORDS_W-1:0] words_q, words_d;

  logic [31:0]        w_sum;
  logic [POP_W-1:0]   w_pop;
  logic [ACC_W-1:0]   w_pop_ext;
  logic [ACC_W-1:0]   w_acc_sum;
  logic               w_hs;
  logic               w_close;
  logic               w_sum_unused;

  for_test u_for_test (
    .in  (in_data),
    .sum (w_sum)
  );

  // A 32-bit word has at most 32 ones, so only the low bits carry information.
  assign w_pop        = w_sum[POP_W-1:0];
  assign w_sum_unused = ^w_sum[31:POP_W];
  assign w_pop_ext    = {{(ACC_W-POP_W){1'b0}}, w_pop};
  assign w_acc_sum    = acc_q + w_pop_ext;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);

  assign w_hs    = in_valid && in_ready;
  // Either a full frame or an early in_last closes; both at once close only once.
  assign w_close = (cnt_q == LAST_IDX) || in_last;

  // State, accumulator and result registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      total_q <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      words_q <= words_d;
    end
  end

  // Next-state and datapath: accumulate in ACCUM, hold the result in HOLD.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    words_d = words_q;
    if (state_q == ACCUM) begin
      if (w_hs) begin
        if (w_close) begin
          total_d = w_acc_sum;
          words_d = cnt_q + 8'd1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          acc_d = w_acc_sum;
          cnt_d = cnt_q + 8'd1;
        end
      end
    end else begin
      // Result stays stable until taken; input reopens on the following cycle.
      if (out_ready) begin
        state_d = ACCUM;
      end
    end
  end

  // Results are registered and retained after the downstream accepts them.
  assign out_total = total_q;
  assign out_words = words_q;

endmodule : popcount_frame_acc
`default_nettype wire

// File: tb/tb_popcount_frame_acc.sv
`default_nettype none
// ============================================================================
// Module  : tb_popcount_frame_acc
// Brief   : Self-checking bench for popcount_frame_acc (FRAME_LEN=8 and 1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_popcount_frame_acc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [15:0] out_total0, out_total1;
  logic [7:0]  out_words0, out_words1;

  int checks = 0;
  int failures = 0;

  // Frame-level reference model, one slot per DUT.
  int fl [2] = '{8, 1};
  int m_busy [2];
  int m_sum [2];
  int m_cnt [2];
  int m_total [2];
  int m_words [2];

  popcount_frame_acc #(.FRAME_LEN(8), .ACC_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_total(out_total0), .out_words(out_words0)
  );

  popcount_frame_acc #(.FRAME_LEN(1), .ACC_W(16)) u_dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_total(out_total1), .out_words(out_words1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: words accepted whenever no result is pending; a frame closes on
  // in_last or when it reaches its maximum length.
  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_busy[k] = 0; m_sum[k] = 0; m_cnt[k] = 0; m_total[k] = 0; m_words[k] = 0;
      end else if (m_busy[k] == 0) begin
        if (in_valid) begin
          m_sum[k] = m_sum[k] + $countones(in_data);
          m_cnt[k] = m_cnt[k] + 1;
          if (in_last || m_cnt[k] == fl[k]) begin
            m_total[k] = m_sum[k];
            m_words[k] = m_cnt[k];
            m_sum[k] = 0;
            m_cnt[k] = 0;
            m_busy[k] = 1;
          end
        end
      end else if (out_ready) begin
        m_busy[k] = 0;
      end
    end
  end

  // Compare both DUTs against the model every cycle.
  always @(negedge clk) begin
    chk("d0_in_ready",  {31'd0, in_ready0},  {31'd0, m_busy[0] == 0});
    chk("d0_out_valid", {31'd0, out_valid0}, {31'd0, m_busy[0] != 0});
    chk("d0_out_total", {16'd0, out_total0}, m_total[0]);
    chk("d0_out_words", {24'd0, out_words0}, m_words[0]);
    chk("d1_in_ready",  {31'd0, in_ready1},  {31'd0, m_busy[1] == 0});
    chk("d1_out_valid", {31'd0, out_valid1}, {31'd0, m_busy[1] != 0});
    chk("d1_out_total", {16'd0, out_total1}, m_total[1]);
    chk("d1_out_words", {24'd0, out_words1}, m_words[1]);
  end

  // Offer one word until the FRAME_LEN=8 DUT takes it, then idle for gap cycles.
  // Entered and left one time unit after a rising edge.
  task automatic send(input logic [31:0] d, input logic last, input int gap);
    int n;
    logic rdy;
    in_valid = 1'b1; in_data = d; in_last = last;
    n = 0;
    forever begin
      @(negedge clk); rdy = in_ready0;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 50) begin
        checks++; failures++;
        $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    for (int g = 0; g < n; g++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("reset_out_valid", {31'd0, out_valid0}, 0);
    chk("reset_out_total", {16'd0, out_total0}, 0);
    chk("reset_out_words", {24'd0, out_words0}, 0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    chk("reset_in_ready", {31'd0, in_ready0}, 1);

    // Full-ones frame, back to back.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(32'hFFFF_FFFF, 1'b0, 0);
    chk("ones_valid", {31'd0, out_valid0}, 1);
    chk("ones_total", {16'd0, out_total0}, 256);
    chk("ones_words", {24'd0, out_words0}, 8);
    chk("ones_ready_low", {31'd0, in_ready0}, 0);
    idle(1);
    chk("ones_ready_back", {31'd0, in_ready0}, 1);
    chk("ones_valid_drop", {31'd0, out_valid0}, 0);

    // Short frame with gaps.
    send(32'h1, 1'b0, 2);
    send(32'h3, 1'b0, 1);
    send(32'h7, 1'b1, 0);
    chk("short_total", {16'd0, out_total0}, 6);
    chk("short_words", {24'd0, out_words0}, 3);
    idle(2);

    // Backpressure.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h0000_FFFF, 1'b0, 0);
    in_valid = 1'b1; in_data = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, out_valid0}, 1);
      chk("bp_ready", {31'd0, in_ready0}, 0);
      chk("bp_total", {16'd0, out_total0}, 128);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(1);
    chk("bp_accepted", {31'd0, out_valid0}, 0);
    chk("bp_total_kept", {16'd0, out_total0}, 128);
    idle(2);

    // Zero frame, then a frame proving the accumulator was cleared.
    for (int i = 0; i < 8; i++) send(32'h0, 1'b0, 0);
    chk("zero_total", {16'd0, out_total0}, 0);
    chk("zero_words", {24'd0, out_words0}, 8);
    for (int i = 0; i < 8; i++) send(32'h8000_0000, 1'b0, 0);
    chk("msb_total", {16'd0, out_total0}, 8);
    idle(2);

    // Reset mid-frame, asserted between edges.
    for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF, 1'b0, 0);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_total", {16'd0, out_total0}, 0);
    chk("rst_mid_words", {24'd0, out_words0}, 0);
    chk("rst_mid_valid", {31'd0, out_valid0}, 0);
    chk("rst_mid_d1_total", {16'd0, out_total1}, 0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h1, 1'b0, 0);
    chk("post_rst_total", {16'd0, out_total0}, 8);
    chk("post_rst_words", {24'd0, out_words0}, 8);
    idle(2);

    // FRAME_LEN=1 instance: each word is its own frame.
    send(32'hAAAA_AAAA, 1'b0, 0);
    chk("fl1_a_valid", {31'd0, out_valid1}, 1);
    chk("fl1_a_total", {16'd0, out_total1}, 16);
    chk("fl1_a_words", {24'd0, out_words1}, 1);
    idle(1);
    send(32'h0000_000F, 1'b0, 0);
    chk("fl1_f_total", {16'd0, out_total1}, 4);
    chk("fl1_f_words", {24'd0, out_words1}, 1);
    idle(1);
    send(32'h0, 1'b1, 0);
    chk("close_total", {16'd0, out_total0}, 20);
    chk("close_words", {24'd0, out_words0}, 3);
    idle(2);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: in_data = 32'h0;
        1: in_data = 32'hFFFF_FFFF;
        default: in_data = $urandom;
      endcase
      in_last = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_popcount_frame_acc
`default_nettype wire
